// File: rtl/tlc_ped_scheduler_if.sv
// rtl/tlc_ped_scheduler_if.sv - button/walk/request signal bundle between crosswalk logic, scheduler and tlc
interface tlc_ped_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] btn;
    logic             ped_walk;
    logic             ped_req;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] served;
    logic             timeout;
    logic             busy;
    logic [15:0]      serve_count;

    // Environment side: drives buttons and the walk indication, observes the scheduler.
    modport master (
        output btn, ped_walk,
        input  ped_req, pending, served, timeout, busy, serve_count
    );

    // Scheduler side.
    modport slave (
        input  btn, ped_walk,
        output ped_req, pending, served, timeout, busy, serve_count
    );
endinterface

// File: rtl/tlc_ped_scheduler.sv
// rtl/tlc_ped_scheduler.sv - pedestrian request scheduler for tlc; optional walk statistics via TLC_PED_STATS_EN
module tlc_ped_scheduler #(
    parameter int N_REQ    = 4,
    parameter int MIN_GAP  = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tlc_ped_scheduler_if.slave   bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_WALK = 3'd2;
    localparam logic [2:0] WALK      = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);

    logic [N_REQ-1:0]  btn_q;
    logic              walk_q;
    logic [N_REQ-1:0]  press;
    logic              walk_rise;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              timeout_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [N_REQ-1:0]  pending_q;
    logic [N_REQ-1:0]  served_q;
    logic              ped_req_q;
    logic              timeout_q;
    logic              busy_q;

    assign press     = bus.btn & ~btn_q;
    assign walk_rise = bus.ped_walk & ~walk_q;

    // Edge detectors: previous-cycle copies of the button and walk levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q  <= '0;
            walk_q <= 1'b0;
        end else begin
            btn_q  <= bus.btn;
            walk_q <= bus.ped_walk;
        end
    end

    // Request latch: a walk rise retires everything pending except bits pressed in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            served_q  <= '0;
        end else if (walk_rise) begin
            pending_q <= press;
            served_q  <= pending_q & ~press;
        end else begin
            pending_q <= pending_q | press;
            served_q  <= '0;
        end
    end

    // Next-state decode; a walk rise preempts whatever the scheduler was doing, including a timeout.
    always_comb begin
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (walk_rise)
                    state_next = WALK;
                else if (pending_q != '0)
                    state_next = ISSUE;
            end
            ISSUE: begin
                state_next = walk_rise ? WALK : WAIT_WALK;
            end
            WAIT_WALK: begin
                if (walk_rise) begin
                    state_next = WALK;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next   = ISSUE;
                    timeout_next = 1'b1;
                end
            end
            WALK: begin
                if (!bus.ped_walk)
                    state_next = GAP;
            end
            GAP: begin
                if (walk_rise)
                    state_next = WALK;
                else if (gap_cnt == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ped_req_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            ped_req_q <= (state_next == ISSUE);
            timeout_q <= timeout_next;
            busy_q    <= (state_next != IDLE);
        end
    end

    // Wait counter: cleared while the request is issued, counts cycles spent waiting for a walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= '0;
        else if (state == WAIT_WALK && !walk_rise && wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Gap counter: loaded when the walk ends, counts down to release the scheduler back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (state == WALK && !bus.ped_walk)
            gap_cnt <= GAP_LOAD;
        else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end

`ifdef TLC_PED_STATS_EN
    logic [15:0] serve_cnt_q;

    // Saturating count of walk phases that found at least one pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            serve_cnt_q <= 16'd0;
        else if (walk_rise && pending_q != '0 && serve_cnt_q != 16'hFFFF)
            serve_cnt_q <= serve_cnt_q + 16'd1;
    end

    assign bus.serve_count = serve_cnt_q;
`else
    assign bus.serve_count = 16'd0;
`endif

    assign bus.ped_req = ped_req_q;
    assign bus.pending = pending_q;
    assign bus.served  = served_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_tlc_ped_scheduler.sv
// tb/tb_tlc_ped_scheduler.sv - directed vector bench for tlc_ped_scheduler
module tb_tlc_ped_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tlc_ped_scheduler_if #(.N_REQ(4)) bus ();

    tlc_ped_scheduler #(
        .N_REQ    (4),
        .MIN_GAP  (16),
        .MAX_WAIT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  btn;
        logic        walk;
        int          n;
        logic        req;
        logic [3:0]  pend;
        logic [3:0]  srv;
        logic        to;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] b, input logic w, input int n,
                       input logic rq, input logic [3:0] p, input logic [3:0] s,
                       input logic t, input logic bz, input logic [15:0] c);
        vec_t v;
        v.btn = b; v.walk = w; v.n = n; v.req = rq; v.pend = p;
        v.srv = s; v.to = t; v.busy = bz; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef TLC_PED_STATS_EN
        return c;
`else
        return 16'd0 & c;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},     32'(bus.ped_req),     32'd0);
        chk({tag, "_pending"}, 32'(bus.pending),     32'd0);
        chk({tag, "_served"},  32'(bus.served),      32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout),     32'd0);
        chk({tag, "_busy"},    32'(bus.busy),        32'd0);
        chk({tag, "_count"},   32'(bus.serve_count), 32'd0);
    endtask

    initial begin
        logic seen_req;
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.btn      = 4'b0000;
        bus.ped_walk = 1'b0;

        //  btn     walk n   req pend    served  to   busy cnt
        add(4'b0100, 0, 1,  0, 4'b0100, 4'b0000, 0, 0, 0);
        add(4'b0000, 0, 1,  1, 4'b0100, 4'b0000, 0, 1, 0);
        add(4'b0000, 0, 1,  0, 4'b0100, 4'b0000, 0, 1, 0);
        add(4'b0000, 0, 3,  0, 4'b0100, 4'b0000, 0, 1, 0);
        add(4'b0000, 1, 1,  0, 4'b0000, 4'b0100, 0, 1, 1);
        add(4'b0000, 1, 1,  0, 4'b0000, 4'b0000, 0, 1, 1);
        add(4'b0000, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 1);
        add(4'b0000, 0, 3,  0, 4'b0000, 4'b0000, 0, 1, 1);
        add(4'b0001, 0, 1,  0, 4'b0001, 4'b0000, 0, 1, 1);
        add(4'b0000, 0, 12, 0, 4'b0001, 4'b0000, 0, 0, 1);
        add(4'b0000, 0, 1,  1, 4'b0001, 4'b0000, 0, 1, 1);
        add(4'b0000, 0, 1,  0, 4'b0001, 4'b0000, 0, 1, 1);
        add(4'b0000, 1, 1,  0, 4'b0000, 4'b0001, 0, 1, 2);
        add(4'b0000, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 2);
        add(4'b0000, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 2);
        add(4'b0010, 0, 1,  0, 4'b0010, 4'b0000, 0, 0, 2);
        add(4'b0000, 0, 1,  1, 4'b0010, 4'b0000, 0, 1, 2);
        add(4'b0000, 0, 64, 0, 4'b0010, 4'b0000, 0, 1, 2);
        add(4'b0000, 0, 1,  1, 4'b0010, 4'b0000, 1, 1, 2);
        add(4'b0000, 0, 64, 0, 4'b0010, 4'b0000, 0, 1, 2);
        add(4'b0000, 0, 1,  1, 4'b0010, 4'b0000, 1, 1, 2);
        add(4'b0000, 0, 1,  0, 4'b0010, 4'b0000, 0, 1, 2);
        add(4'b1000, 0, 1,  0, 4'b1010, 4'b0000, 0, 1, 2);
        add(4'b0000, 0, 2,  0, 4'b1010, 4'b0000, 0, 1, 2);
        add(4'b0000, 1, 1,  0, 4'b0000, 4'b1010, 0, 1, 3);
        add(4'b0000, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 3);
        add(4'b0000, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 3);
        add(4'b0001, 0, 1,  0, 4'b0001, 4'b0000, 0, 0, 3);
        add(4'b0000, 0, 1,  1, 4'b0001, 4'b0000, 0, 1, 3);
        add(4'b0000, 0, 1,  0, 4'b0001, 4'b0000, 0, 1, 3);
        add(4'b0001, 1, 1,  0, 4'b0001, 4'b0000, 0, 1, 4);
        add(4'b0000, 1, 1,  0, 4'b0001, 4'b0000, 0, 1, 4);
        add(4'b0000, 0, 1,  0, 4'b0001, 4'b0000, 0, 1, 4);
        add(4'b0000, 0, 16, 0, 4'b0001, 4'b0000, 0, 0, 4);
        add(4'b0000, 0, 1,  1, 4'b0001, 4'b0000, 0, 1, 4);
        add(4'b0000, 0, 1,  0, 4'b0001, 4'b0000, 0, 1, 4);

        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk_all_zero("idle_after_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            bus.btn      = vecs[i].btn;
            bus.ped_walk = vecs[i].walk;
            for (int c = 0; c < vecs[i].n; c++) begin
                step();
                if (c < vecs[i].n - 1) begin
                    chk($sformatf("v%0d_c%0d_req_quiet", i, c), 32'(bus.ped_req), 32'd0);
                    chk($sformatf("v%0d_c%0d_to_quiet", i, c),  32'(bus.timeout), 32'd0);
                end
            end
            chk($sformatf("v%0d_req", i),     32'(bus.ped_req),     32'(vecs[i].req));
            chk($sformatf("v%0d_pending", i), 32'(bus.pending),     32'(vecs[i].pend));
            chk($sformatf("v%0d_served", i),  32'(bus.served),      32'(vecs[i].srv));
            chk($sformatf("v%0d_timeout", i), 32'(bus.timeout),     32'(vecs[i].to));
            chk($sformatf("v%0d_busy", i),    32'(bus.busy),        32'(vecs[i].busy));
            chk($sformatf("v%0d_count", i),   32'(bus.serve_count), 32'(exp_cnt(vecs[i].cnt)));
        end

        // Asynchronous reset in the middle of WAIT_WALK with a request pending.
        bus.btn      = 4'b0000;
        bus.ped_walk = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        seen_req = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (bus.ped_req) seen_req = 1'b1;
        end
        chk("no_req_after_reset", 32'(seen_req), 32'd0);
        chk("idle_busy_after_reset", 32'(bus.busy), 32'd0);
        chk("idle_pending_after_reset", 32'(bus.pending), 32'd0);

        // A button held high across reset release counts as one press.
        #2;
        rst_n   = 1'b0;
        bus.btn = 4'b1000;
        step();
        step();
        rst_n = 1'b1;
        chk("held_btn_in_reset_pending", 32'(bus.pending), 32'd0);
        step();
        chk("held_btn_pending", 32'(bus.pending), 32'b1000);
        chk("held_btn_req_early", 32'(bus.ped_req), 32'd0);
        step();
        chk("held_btn_req", 32'(bus.ped_req), 32'd1);
        step();
        chk("held_btn_req_width", 32'(bus.ped_req), 32'd0);
        chk("held_btn_pending_merged", 32'(bus.pending), 32'b1000);
        bus.btn = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
